writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Shares the single register-file write port between the 1-cycle execute result (EX) and
//  long-latency load/MDU returns (LSU). Holds a 32-entry pending-write scoreboard; raises
//  issue_stall_o on RAW/WAW hazards against outstanding long ops. Sits between EX/LSU and register_file.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive EX-blocked cycles before EX is forced to win arbitration (1..15)
// PORTS
//  clk_i          in   1   clock
//  rst_ni         in   1   asynchronous, active-low reset
//  ex_valid_i     in   1   EX result valid
//  ex_ready_o     out  1   EX result accepted this cycle
//  ex_rd_i        in   5   EX destination
//  ex_data_i      in   32  EX result
//  lsu_valid_i    in   1   long-op result valid
//  lsu_ready_o    out  1   long-op result accepted this cycle
//  lsu_rd_i       in   5   long-op destination
//  lsu_data_i     in   32  long-op result
//  issue_valid_i  in   1   decode presenting an instruction
//  issue_long_i   in   1   instruction writes back via LSU port
//  issue_rd_i     in   5   its destination
//  issue_rs1_i    in   5   source 1
//  issue_rs2_i    in   5   source 2
//  issue_stall_o  out  1   hold decode; instruction not issued
//  rd_we_o        out  1   to register_file write enable
//  rd_addr_o      out  5   to register_file write address
//  rd_data_o      out  32  to register_file write data
//  pending_o      out  32  scoreboard, bit n = xn has outstanding long write
// BEHAVIOUR
//  Reset: pending=0, starve_cnt=0; while rst_ni low all outputs 0 (ex/lsu_ready_o=0, issue_stall_o=0).
//  Handshake: valid/ready; transfer when valid&ready. Ready is combinational from valids and state;
//   valid must not depend on ready. Source holds rd/data stable until transfer.
//  Arbitration (combinational, 0 latency): one grant per cycle.
//   - only one valid -> it wins.
//   - both valid -> LSU wins unless starve_cnt == STARVE_LIMIT, then EX wins.
//   - starve_cnt: +1 each cycle ex_valid&!ex_ready (saturating at STARVE_LIMIT); cleared on EX transfer
//     or when ex_valid low.
//  Write port: rd_we_o = transfer & (granted rd != 0); rd_addr_o/rd_data_o = granted source (0 if none).
//   rd==0 transfers complete normally with rd_we_o=0.
//  Scoreboard:
//   - issue accepted = issue_valid_i & !issue_stall_o.
//   - set pending[issue_rd_i] on accepted issue with issue_long_i & issue_rd_i!=0.
//   - clear pending[lsu_rd_i] on LSU transfer. Set and clear same cycle on different regs: both apply.
//   - issue_stall_o = issue_valid_i & (pending[rs1] | pending[rs2] | (pending[rd] & rd!=0)).
//     x0 never pending. Stall uses registered pending only: a reg cleared this cycle still stalls
//     this cycle; next cycle register_file holds the new value (no bypass needed).
//   - LSU transfer to a non-pending rd: write performed, pending unchanged; assertion flags it.
//  Reset mid-operation: scoreboard and counter cleared immediately (async); in-flight transfers lost.
// STRUCTURE
//  rv32_pkg: reg_addr_t (logic[4:0]), xlen_t (logic[31:0]), NUM_REGS=32.
//  Sub-module wb_scoreboard (pending vector, set/clear, hazard lookup); arbiter + counter in top.
// TESTING
//  Reset: rst_ni=0 mid-traffic -> rd_we_o=0, pending_o=0, both ready=0 next sample.
//  EX only: ex rd=5 data=0xDEAD_BEEF -> same cycle rd_we_o=1, addr=5, ex_ready_o=1.
//  Contention, STARVE_LIMIT=4: both valid held 6 cycles -> LSU wins cycles 0-3, EX wins cycle 4.
//  RAW: long issue rd=7, then issue rs1=7 -> stall until LSU rd=7 transfer cycle+1; pending_o[7] 1->0.
//  WAW + x0: long issue rd=0 -> pending_o stays 0; second long issue rd=7 while pending[7] -> stall.
//  Same-cycle: LSU rd=3 transfer + long issue rd=9 -> pending_o = bit9 only next cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared register-file types and the write-port grant encoding.
package rv32_pkg;

  localparam int NUM_REGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_EX   = 2'd1,
    GNT_LSU  = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register that has an
// outstanding long-latency write. The hazard lookup reads only the registered
// vector, so a register cleared this cycle still reports busy this cycle.
module wb_scoreboard
  import rv32_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_en_i,
  input  reg_addr_t           set_idx_i,
  input  logic                clr_en_i,
  input  reg_addr_t           clr_idx_i,
  input  reg_addr_t           rs1_i,
  input  reg_addr_t           rs2_i,
  input  reg_addr_t           rd_i,
  output logic                hazard_o,
  output logic [NUM_REGS-1:0] pending_o
);

  logic [NUM_REGS-1:0] pending_d, pending_q;

  // Next pending vector: clear the returning register, set the newly issued one.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_idx_i] = 1'b0;
    if (set_en_i) pending_d[set_idx_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Scoreboard state; asynchronous reset drops every outstanding write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  // RAW on either source, WAW on the destination (x0 never conflicts).
  always_comb begin
    hazard_o = pending_q[rs1_i] | pending_q[rs2_i] |
               (pending_q[rd_i] & (rd_i != '0));
  end

  assign pending_o = pending_q;

  // A long-op return must correspond to a write that is actually outstanding.
  a_clr_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (clr_en_i && (clr_idx_i != '0)) |-> pending_q[clr_idx_i]);

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: shares the single register-file write port between the
// one-cycle EX result and long-latency LSU/MDU returns. LSU normally wins a
// collision; after STARVE_LIMIT consecutive blocked cycles EX is forced through.
module writeback_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ex_valid_i,
  output logic                ex_ready_o,
  input  reg_addr_t           ex_rd_i,
  input  xlen_t               ex_data_i,
  input  logic                lsu_valid_i,
  output logic                lsu_ready_o,
  input  reg_addr_t           lsu_rd_i,
  input  xlen_t               lsu_data_i,
  input  logic                issue_valid_i,
  input  logic                issue_long_i,
  input  reg_addr_t           issue_rd_i,
  input  reg_addr_t           issue_rs1_i,
  input  reg_addr_t           issue_rs2_i,
  output logic                issue_stall_o,
  output logic                rd_we_o,
  output reg_addr_t           rd_addr_o,
  output xlen_t               rd_data_o,
  output logic [NUM_REGS-1:0] pending_o
);

  // Four bits cover the full 1..15 range of STARVE_LIMIT.
  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LIMIT = cnt_t'(STARVE_LIMIT);

  // Saturating increment of the EX starvation counter.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v >= LIMIT) ? LIMIT : cnt_t'(v + cnt_t'(1));
  endfunction

  grant_e grant;
  cnt_t   starve_d, starve_q;
  logic   hazard;
  logic   sb_set_en;
  logic   sb_clr_en;

  // Grant selection: lone requester wins; on collision LSU wins unless EX is starved.
  always_comb begin
    grant = GNT_NONE;
    if (rst_ni) begin
      if (ex_valid_i && (!lsu_valid_i || (starve_q == LIMIT))) grant = GNT_EX;
      else if (lsu_valid_i)                                    grant = GNT_LSU;
    end
  end

  // Write-port mux and handshakes; everything is zero while reset is held.
  always_comb begin
    ex_ready_o  = (grant == GNT_EX);
    lsu_ready_o = (grant == GNT_LSU);
    rd_addr_o   = '0;
    rd_data_o   = '0;
    case (grant)
      GNT_EX: begin
        rd_addr_o = ex_rd_i;
        rd_data_o = ex_data_i;
      end
      GNT_LSU: begin
        rd_addr_o = lsu_rd_i;
        rd_data_o = lsu_data_i;
      end
      default: ;
    endcase
    rd_we_o = (grant != GNT_NONE) && (rd_addr_o != '0);
  end

  // Starvation counter: counts cycles EX waits; restarts when EX drains or drops valid.
  always_comb begin
    starve_d = '0;
    if (ex_valid_i && !ex_ready_o) starve_d = sat_inc(starve_q);
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end

  // Issue gating and scoreboard updates.
  always_comb begin
    issue_stall_o = rst_ni & issue_valid_i & hazard;
    sb_set_en     = issue_valid_i & ~issue_stall_o & issue_long_i & (issue_rd_i != '0);
    sb_clr_en     = lsu_ready_o;
  end

  wb_scoreboard u_scoreboard (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .set_en_i  (sb_set_en),
    .set_idx_i (issue_rd_i),
    .clr_en_i  (sb_clr_en),
    .clr_idx_i (lsu_rd_i),
    .rs1_i     (issue_rs1_i),
    .rs2_i     (issue_rs2_i),
    .rd_i      (issue_rd_i),
    .hazard_o  (hazard),
    .pending_o (pending_o)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_writeback_arbiter;

  localparam int LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ex_valid_i, ex_ready_o;
  logic [4:0]  ex_rd_i;
  logic [31:0] ex_data_i;
  logic        lsu_valid_i, lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        issue_valid_i, issue_long_i;
  logic [4:0]  issue_rd_i, issue_rs1_i, issue_rs2_i;
  logic        issue_stall_o, rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic [31:0] pending_o;

  always #5 clk_i = ~clk_i;

  writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .issue_valid_i(issue_valid_i), .issue_long_i(issue_long_i), .issue_rd_i(issue_rd_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .issue_stall_o(issue_stall_o),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .pending_o(pending_o)
  );

  int checks = 0;
  int errors = 0;

  // Model state: set of registers awaiting a long write, and how long EX has waited.
  logic [31:0] pend_m;
  int          streak_m;
  // Model expectations for the current cycle.
  logic        e_exr, e_lsur, e_stall, e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Derive what the outputs must be from the current inputs and model state.
  task automatic model_eval();
    e_exr = 0; e_lsur = 0; e_stall = 0; e_we = 0; e_addr = '0; e_data = '0;
    if (!rst_ni) begin
      pend_m   = '0;
      streak_m = 0;
    end else begin
      if (ex_valid_i && (!lsu_valid_i || streak_m == LIMIT)) e_exr = 1;
      else if (lsu_valid_i) e_lsur = 1;
      if (e_exr)  begin e_addr = ex_rd_i;  e_data = ex_data_i;  end
      if (e_lsur) begin e_addr = lsu_rd_i; e_data = lsu_data_i; end
      e_we = (e_exr || e_lsur) && (e_addr != 0);
      e_stall = issue_valid_i && (pend_m[issue_rs1_i] || pend_m[issue_rs2_i] ||
                                  (issue_rd_i != 0 && pend_m[issue_rd_i]));
    end
  endtask

  task automatic model_check();
    model_eval();
    chk("ex_ready",    {31'd0, ex_ready_o},    {31'd0, e_exr});
    chk("lsu_ready",   {31'd0, lsu_ready_o},   {31'd0, e_lsur});
    chk("issue_stall", {31'd0, issue_stall_o}, {31'd0, e_stall});
    chk("rd_we",       {31'd0, rd_we_o},       {31'd0, e_we});
    chk("rd_addr",     {27'd0, rd_addr_o},     {27'd0, e_addr});
    chk("rd_data",     rd_data_o,              e_data);
    chk("pending",     pending_o,              pend_m);
  endtask

  // Advance the model at the clock edge using this cycle's expectations.
  task automatic model_update();
    if (rst_ni) begin
      if (e_lsur) pend_m[lsu_rd_i] = 1'b0;
      if (issue_valid_i && !e_stall && issue_long_i && issue_rd_i != 0) pend_m[issue_rd_i] = 1'b1;
      if (ex_valid_i && !e_exr) streak_m = (streak_m + 1 > LIMIT) ? LIMIT : streak_m + 1;
      else streak_m = 0;
    end
  endtask

  task automatic tick_a();
    @(negedge clk_i);
    model_check();
  endtask

  task automatic tick_b();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic tick();
    tick_a();
    tick_b();
  endtask

  task automatic idle();
    ex_valid_i = 0; lsu_valid_i = 0; issue_valid_i = 0; issue_long_i = 0;
    ex_rd_i = 0; ex_data_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
    issue_rd_i = 0; issue_rs1_i = 0; issue_rs2_i = 0;
  endtask

  task automatic issue(input logic lng, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid_i = 1; issue_long_i = lng; issue_rd_i = rd; issue_rs1_i = rs1; issue_rs2_i = rs2;
  endtask

  initial begin
    bit         pat [6];
    logic [4:0] lsu_list [5];
    int         li;

    pend_m = '0; streak_m = 0;
    idle();
    rst_ni = 0;
    // Reset held with traffic present: everything must read zero.
    ex_valid_i = 1; ex_rd_i = 5'd3; lsu_valid_i = 1; lsu_rd_i = 5'd4; issue(1'b0, 5'd1, 5'd2, 5'd3);
    tick_a();
    chk("rst_rd_we", {31'd0, rd_we_o}, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready_o}, 32'd0);
    tick_b();
    rst_ni = 1;
    idle();
    tick();

    // EX alone is written through in the same cycle.
    ex_valid_i = 1; ex_rd_i = 5'd5; ex_data_i = 32'hDEAD_BEEF;
    tick_a();
    chk("ex_only_we", {31'd0, rd_we_o}, 32'd1);
    chk("ex_only_addr", {27'd0, rd_addr_o}, 32'd5);
    chk("ex_only_data", rd_data_o, 32'hDEAD_BEEF);
    chk("ex_only_ready", {31'd0, ex_ready_o}, 32'd1);
    tick_b();
    // EX write to x0 completes without a write enable.
    ex_rd_i = 5'd0; ex_data_i = 32'h1234_5678;
    tick_a();
    chk("ex_x0_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("ex_x0_we", {31'd0, rd_we_o}, 32'd0);
    tick_b();
    idle();

    // RAW: long op to x7, dependent instruction stalls until the return cycle + 1.
    issue(1'b1, 5'd7, 5'd0, 5'd0);
    tick_a(); chk("raw_issue_stall", {31'd0, issue_stall_o}, 32'd0); tick_b();
    issue(1'b0, 5'd8, 5'd7, 5'd0);
    tick_a();
    chk("raw_stall", {31'd0, issue_stall_o}, 32'd1);
    chk("raw_pend7_set", {31'd0, pending_o[7]}, 32'd1);
    tick_b();
    lsu_valid_i = 1; lsu_rd_i = 5'd7; lsu_data_i = 32'hCAFE_0007;
    tick_a();
    chk("raw_stall_ret_cycle", {31'd0, issue_stall_o}, 32'd1);
    chk("raw_lsu_addr", {27'd0, rd_addr_o}, 32'd7);
    tick_b();
    lsu_valid_i = 0;
    tick_a();
    chk("raw_stall_cleared", {31'd0, issue_stall_o}, 32'd0);
    chk("raw_pend7_clr", {31'd0, pending_o[7]}, 32'd0);
    tick_b();
    idle();

    // WAW and x0: long op to x0 never becomes pending; second long op to x7 stalls.
    issue(1'b1, 5'd0, 5'd1, 5'd2);
    tick();
    issue(1'b1, 5'd7, 5'd1, 5'd2);
    tick_a(); chk("x0_not_pending", pending_o, 32'd0); tick_b();
    tick_a();
    chk("waw_stall", {31'd0, issue_stall_o}, 32'd1);
    chk("waw_pending", pending_o, 32'h0000_0080);
    tick_b();
    idle(); lsu_valid_i = 1; lsu_rd_i = 5'd7;
    tick();
    idle();

    // Same cycle: x3 returns while a long op to x9 issues.
    issue(1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    issue(1'b1, 5'd9, 5'd0, 5'd0); lsu_valid_i = 1; lsu_rd_i = 5'd3;
    tick();
    idle();
    tick_a(); chk("same_cycle_pending", pending_o, 32'h0000_0200); tick_b();
    lsu_valid_i = 1; lsu_rd_i = 5'd9;
    tick();
    idle();

    // Contention: LSU wins four cycles, then the starved EX is forced through.
    for (int r = 10; r < 15; r++) begin
      issue(1'b1, 5'(r), 5'd0, 5'd0);
      lsu_list[r - 10] = 5'(r);
      tick();
    end
    idle();
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    li = 0;
    ex_valid_i = 1; ex_rd_i = 5'd2; ex_data_i = 32'hE000_0000;
    for (int k = 0; k < 6; k++) begin
      lsu_valid_i = 1; lsu_rd_i = lsu_list[li]; lsu_data_i = 32'h1000_0000 + 32'(k);
      tick_a();
      chk("contention_ex_ready", {31'd0, ex_ready_o}, {31'd0, pat[k]});
      chk("contention_lsu_ready", {31'd0, lsu_ready_o}, {31'd0, !pat[k]});
      tick_b();
      if (pat[k]) ex_data_i = ex_data_i + 32'd1;
      else if (li < 4) li++;
    end
    idle();
    tick_a(); chk("contention_drained", pending_o, 32'd0); tick_b();

    // Reset mid-traffic clears the scoreboard and blocks both sources.
    issue(1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    ex_valid_i = 1; ex_rd_i = 5'd6; lsu_valid_i = 1; lsu_rd_i = 5'd4; issue(1'b0, 5'd1, 5'd4, 5'd0);
    rst_ni = 0;
    tick_a();
    chk("midrst_rd_we", {31'd0, rd_we_o}, 32'd0);
    chk("midrst_pending", pending_o, 32'd0);
    chk("midrst_ex_ready", {31'd0, ex_ready_o}, 32'd0);
    chk("midrst_lsu_ready", {31'd0, lsu_ready_o}, 32'd0);
    tick_b();
    rst_ni = 1;
    idle();
    tick();

    // Randomized traffic with holding sources and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if (!rst_ni) begin
        rst_ni = 1; ex_valid_i = 0; lsu_valid_i = 0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst_ni = 0;
      end
      if (!ex_valid_i || e_exr) begin
        ex_valid_i = ($urandom_range(0, 99) < 60);
        ex_rd_i    = 5'($urandom_range(0, 31));
        ex_data_i  = $urandom;
      end
      if (!lsu_valid_i || e_lsur) begin
        lsu_valid_i = 0;
        if (pend_m != 0 && $urandom_range(0, 99) < 55) begin
          int start;
          start = $urandom_range(0, 31);
          for (int j = 0; j < 32; j++) begin
            int r;
            r = (start + j) % 32;
            if (pend_m[r]) begin
              lsu_valid_i = 1; lsu_rd_i = 5'(r); lsu_data_i = $urandom;
              break;
            end
          end
        end
      end
      issue_valid_i = ($urandom_range(0, 99) < 70);
      issue_long_i  = ($urandom_range(0, 99) < 40);
      issue_rd_i    = 5'($urandom_range(0, 15));
      issue_rs1_i   = 5'($urandom_range(0, 15));
      issue_rs2_i   = 5'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
